// File: rtl/pc_file.sv
// Per-thread PC / EPC / exception-mode file for the barrel-threaded core.
// Applies one prioritised redirect per thread per cycle; fetch reads it combinationally.
module pc_file #(
    parameter int unsigned NUM_TRD  = 8,
    parameter int unsigned TW       = $clog2(NUM_TRD),
    parameter int unsigned PC_W     = 32,
    parameter int unsigned PC_INC   = 1,
    parameter int unsigned START_PC = 0,
    parameter int unsigned HANDLER  = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv_vld_i,
    input  logic [TW-1:0]      adv_trd_i,
    input  logic               jmp_i,
    input  logic [TW-1:0]      jmp_trd_i,
    input  logic [PC_W-1:0]    jmp_pc_i,
    input  logic               i_miss_i,
    input  logic [TW-1:0]      i_miss_trd_i,
    input  logic [PC_W-1:0]    i_miss_pc_i,
    input  logic               d_miss_i,
    input  logic [TW-1:0]      d_miss_trd_i,
    input  logic [PC_W-1:0]    d_miss_pc_i,
    input  logic               exp_i,
    input  logic [TW-1:0]      exp_trd_i,
    input  logic [PC_W-1:0]    exp_pc_i,
    input  logic               ret_i,
    input  logic [TW-1:0]      ret_trd_i,
    input  logic [TW-1:0]      rd_trd_i,
    output logic [PC_W-1:0]    rd_pc_o,
    output logic [PC_W-1:0]    rd_epc_o,
    output logic [NUM_TRD-1:0] exp_mode_o,
    output logic [NUM_TRD-1:0] pc_upd_o
);

    localparam logic [PC_W-1:0] INC_C   = PC_W'(PC_INC);
    localparam logic [PC_W-1:0] START_C = PC_W'(START_PC);
    localparam logic [PC_W-1:0] HNDL_C  = PC_W'(HANDLER);

    logic [PC_W-1:0]    pc_q  [NUM_TRD];
    logic [PC_W-1:0]    pc_d  [NUM_TRD];
    logic [PC_W-1:0]    epc_q [NUM_TRD];
    logic [PC_W-1:0]    epc_d [NUM_TRD];
    logic [NUM_TRD-1:0] mode_q, mode_d;
    logic [NUM_TRD-1:0] upd_q, upd_d;
    logic               rd_ok;

    // Thread indices >= NUM_TRD never match any t below, so they are dropped.
    always_comb begin
        for (int t = 0; t < NUM_TRD; t++) begin
            pc_d[t]   = pc_q[t];
            epc_d[t]  = epc_q[t];
            mode_d[t] = mode_q[t];
            upd_d[t]  = 1'b1;
            if (exp_i && exp_trd_i == TW'(t) && !mode_q[t]) begin
                pc_d[t]   = HNDL_C;
                epc_d[t]  = exp_pc_i;
                mode_d[t] = 1'b1;
            end else if (ret_i && ret_trd_i == TW'(t) && mode_q[t]) begin
                pc_d[t]   = epc_q[t];
                mode_d[t] = 1'b0;
            end else if (d_miss_i && d_miss_trd_i == TW'(t)) begin
                pc_d[t] = d_miss_pc_i;
            end else if (i_miss_i && i_miss_trd_i == TW'(t)) begin
                pc_d[t] = i_miss_pc_i;
            end else if (jmp_i && jmp_trd_i == TW'(t)) begin
                pc_d[t] = jmp_pc_i;
            end else if (adv_vld_i && adv_trd_i == TW'(t)) begin
                pc_d[t] = pc_q[t] + INC_C;
            end else begin
                upd_d[t] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TRD; t++) begin
                pc_q[t]  <= START_C;
                epc_q[t] <= START_C;
            end
            mode_q <= '0;
            upd_q  <= '0;
        end else begin
            for (int t = 0; t < NUM_TRD; t++) begin
                pc_q[t]  <= pc_d[t];
                epc_q[t] <= epc_d[t];
            end
            mode_q <= mode_d;
            upd_q  <= upd_d;
        end
    end

    // Unpopulated thread slots read back as the reset PC.
    assign rd_ok      = {1'b0, rd_trd_i} < (TW+1)'(NUM_TRD);
    assign rd_pc_o    = rd_ok ? pc_q[rd_trd_i]  : START_C;
    assign rd_epc_o   = rd_ok ? epc_q[rd_trd_i] : START_C;
    assign exp_mode_o = mode_q;
    assign pc_upd_o   = upd_q;

endmodule

// File: tb/tb_pc_file.sv
// Scoreboard bench for pc_file: default 8-thread/32-bit instance plus
// a 6-thread/8-bit instance for wrap and out-of-range thread indices.
module tb_pc_file;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-thread, 32-bit instance
    logic        adv, jmp, im, dm, ex, rt;
    logic [2:0]  adv_t, jmp_t, im_t, dm_t, ex_t, rt_t, rd_t;
    logic [31:0] jmp_p, im_p, dm_p, ex_p;
    logic [31:0] rd_pc, rd_epc;
    logic [7:0]  mode, upd;

    // 6-thread, 8-bit instance
    logic        s_adv, s_jmp, s_ex, s_rt;
    logic [2:0]  s_adv_t, s_jmp_t, s_ex_t, s_rt_t, s_rd_t;
    logic [7:0]  s_jmp_p, s_rd_pc, s_rd_epc;
    logic [5:0]  s_mode, s_upd;

    pc_file u_dut (
        .clk(clk), .rst_n(rst_n),
        .adv_vld_i(adv), .adv_trd_i(adv_t),
        .jmp_i(jmp), .jmp_trd_i(jmp_t), .jmp_pc_i(jmp_p),
        .i_miss_i(im), .i_miss_trd_i(im_t), .i_miss_pc_i(im_p),
        .d_miss_i(dm), .d_miss_trd_i(dm_t), .d_miss_pc_i(dm_p),
        .exp_i(ex), .exp_trd_i(ex_t), .exp_pc_i(ex_p),
        .ret_i(rt), .ret_trd_i(rt_t),
        .rd_trd_i(rd_t), .rd_pc_o(rd_pc), .rd_epc_o(rd_epc),
        .exp_mode_o(mode), .pc_upd_o(upd)
    );

    pc_file #(.NUM_TRD(6), .PC_W(8)) u_small (
        .clk(clk), .rst_n(rst_n),
        .adv_vld_i(s_adv), .adv_trd_i(s_adv_t),
        .jmp_i(s_jmp), .jmp_trd_i(s_jmp_t), .jmp_pc_i(s_jmp_p),
        .i_miss_i(1'b0), .i_miss_trd_i(3'd0), .i_miss_pc_i(8'd0),
        .d_miss_i(1'b0), .d_miss_trd_i(3'd0), .d_miss_pc_i(8'd0),
        .exp_i(s_ex), .exp_trd_i(s_ex_t), .exp_pc_i(8'h5A),
        .ret_i(s_rt), .ret_trd_i(s_rt_t),
        .rd_trd_i(s_rd_t), .rd_pc_o(s_rd_pc), .rd_epc_o(s_rd_epc),
        .exp_mode_o(s_mode), .pc_upd_o(s_upd)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] sample(input int kind);
        case (kind)
            0: return rd_pc;
            1: return rd_epc;
            2: return {24'd0, mode};
            3: return {24'd0, upd};
            4: return {24'd0, s_rd_pc};
            5: return {26'd0, s_upd};
            default: return {26'd0, s_mode};
        endcase
    endfunction

    // Monitor: checks every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            n_chk++;
            act = sample(e.kind);
            if (e.cyc != cyc)
                $display("FAIL %s: stale expectation from cycle %0d", e.name, e.cyc);
            else if (act !== e.val)
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            else
                n_pass++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        adv = 0; jmp = 0; im = 0; dm = 0; ex = 0; rt = 0;
        s_adv = 0; s_jmp = 0; s_ex = 0; s_rt = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        {adv_t, jmp_t, im_t, dm_t, ex_t, rt_t, rd_t} = '0;
        {jmp_p, im_p, dm_p, ex_p} = '0;
        {s_adv_t, s_jmp_t, s_ex_t, s_rt_t, s_rd_t} = '0;
        s_jmp_p = '0;
        tick();
        tick();

        // Reset state, then sequential advance on thread 3
        rst_n = 1'b1;
        rd_t = 3'd3;
        adv = 1; adv_t = 3'd3;
        chk(0, 32'd0, "rst_pc");
        chk(1, 32'd0, "rst_epc");
        chk(2, 32'h00, "rst_mode");
        chk(3, 32'h00, "rst_upd");
        tick();
        chk(0, 32'd1, "adv_pc1");
        chk(3, 32'h08, "adv_upd1");
        tick();
        chk(0, 32'd2, "adv_pc2");
        chk(3, 32'h08, "adv_upd2");
        tick();
        idle();
        chk(0, 32'd3, "adv_pc3");
        chk(3, 32'h08, "adv_upd3");
        tick();

        // Priority d_miss > i_miss > jmp on thread 2, adv on thread 5
        rd_t = 3'd5;
        chk(0, 32'd0, "other_trd_zero");
        chk(3, 32'h00, "idle_upd");
        dm = 1; dm_t = 3'd2; dm_p = 32'h40;
        im = 1; im_t = 3'd2; im_p = 32'h50;
        jmp = 1; jmp_t = 3'd2; jmp_p = 32'h60;
        adv = 1; adv_t = 3'd5;
        tick();
        idle();
        rd_t = 3'd2;
        chk(0, 32'h40, "dmiss_prio");
        chk(3, 32'h24, "multi_upd");
        tick();
        rd_t = 3'd5;
        chk(0, 32'd1, "adv_trd5");

        // Exception entry, nested exception, return
        ex = 1; ex_t = 3'd1; ex_p = 32'h77;
        tick();
        idle();
        rd_t = 3'd1;
        chk(0, 32'h100, "exp_handler");
        chk(1, 32'h77, "exp_epc");
        chk(2, 32'h02, "exp_mode");
        chk(3, 32'h02, "exp_upd");
        ex = 1; ex_t = 3'd1; ex_p = 32'h99;
        jmp = 1; jmp_t = 3'd1; jmp_p = 32'h120;
        tick();
        idle();
        chk(0, 32'h120, "nested_jmp");
        chk(1, 32'h77, "nested_epc");
        chk(2, 32'h02, "nested_mode");
        rt = 1; rt_t = 3'd1;
        tick();
        idle();
        chk(0, 32'h77, "ret_pc");
        chk(2, 32'h00, "ret_mode");
        chk(3, 32'h02, "ret_upd");

        // Stray return falls through to advance
        rt = 1; rt_t = 3'd4;
        adv = 1; adv_t = 3'd4;
        tick();
        idle();
        rd_t = 3'd4;
        chk(0, 32'd1, "stray_ret_adv");
        chk(2, 32'h00, "stray_ret_mode");
        chk(3, 32'h10, "stray_ret_upd");

        // Put every thread into exception mode
        for (int t = 0; t < 8; t++) begin
            ex = 1; ex_t = 3'(t); ex_p = 32'h10 + 32'(t);
            tick();
        end
        idle();
        rd_t = 3'd5;
        chk(2, 32'hFF, "all_mode");
        chk(3, 32'h80, "last_exp_upd");
        chk(0, 32'h100, "trd5_handler");
        chk(1, 32'h15, "trd5_epc");
        adv = 1; adv_t = 3'd2;
        tick();
        idle();

        // Asynchronous reset mid-cycle
        #1;
        rst_n = 1'b0;
        rd_t = 3'd1;
        chk(2, 32'h00, "async_mode");
        chk(0, 32'd0, "async_pc");
        chk(1, 32'd0, "async_epc");
        chk(3, 32'h00, "async_upd");
        tick();
        tick();

        // Narrow instance: wrap and out-of-range threads
        rst_n = 1'b1;
        s_rd_t = 3'd0;
        chk(4, 32'h00, "s_rst_pc");
        s_jmp = 1; s_jmp_t = 3'd0; s_jmp_p = 8'hFF;
        tick();
        idle();
        chk(4, 32'hFF, "s_jmp_ff");
        chk(5, 32'h01, "s_jmp_upd");
        s_adv = 1; s_adv_t = 3'd0;
        tick();
        idle();
        chk(4, 32'h00, "s_wrap");
        chk(5, 32'h01, "s_wrap_upd");
        s_jmp = 1; s_jmp_t = 3'd7; s_jmp_p = 8'h33;
        tick();
        idle();
        chk(5, 32'h00, "s_trd7_ign");
        chk(4, 32'h00, "s_trd7_pc0");
        s_jmp = 1; s_jmp_t = 3'd6; s_jmp_p = 8'h44;
        s_ex = 1; s_ex_t = 3'd6;
        s_adv = 1; s_adv_t = 3'd7;
        tick();
        idle();
        chk(5, 32'h00, "s_trd6_ign");
        chk(6, 32'h00, "s_trd6_mode");
        tick();
        tick();

        n_chk++;
        if (sb.size() != 0)
            $display("FAIL sb_drain: got %0d left expected 0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
